// File: rtl/ep01_a.sv
// Three-input Boolean cell: f = TRUTH_TABLE[{a,b,c}] with a registered copy and rise pulse.
// Define EP01_COUNT_EN to add the saturating high_cnt register and port.
module ep01_a #(
    parameter logic [7:0] TRUTH_TABLE = 8'b1110_0010,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             f,
    output logic             f_q,
`ifdef EP01_COUNT_EN
    output logic             f_rise,
    output logic [CNT_W-1:0] high_cnt
`else
    output logic             f_rise
`endif
);

    if (CNT_W < 2) begin : g_cnt_w_check
        $error("ep01_a: CNT_W must be at least 2");
    end

    assign f = TRUTH_TABLE[{a, b, c}];

    // f_rise compares the incoming f with the old f_q, so it lines up with the f_q 0->1 step.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_q    <= 1'b0;
            f_rise <= 1'b0;
        end else begin
            f_q    <= f;
            f_rise <= f & ~f_q;
        end
    end

`ifdef EP01_COUNT_EN
    // Counts cycles where f_q is already high, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_cnt <= '0;
        end else if (f_q && (high_cnt != {CNT_W{1'b1}})) begin
            high_cnt <= high_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_ep01_a.sv
// Directed self-checking bench for ep01_a: default table, AND3 table and, with
// EP01_COUNT_EN defined, the saturating high-count register.
module tb_ep01_a;

    logic clk = 1'b0;
    logic reset;
    logic a, b, c;
    logic f, f_q, f_rise;
    logic f_and, f_q_and, f_rise_and;
`ifdef EP01_COUNT_EN
    logic [7:0] high_cnt8;
    logic [7:0] high_cnt8_and;
    logic [1:0] high_cnt2;
    logic       f_c2, f_q_c2, f_rise_c2;
`endif

    int check_count = 0;
    int fail_count  = 0;

    always #5 clk = ~clk;

    ep01_a u_dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .c        (c),
        .f        (f),
        .f_q      (f_q),
`ifdef EP01_COUNT_EN
        .f_rise   (f_rise),
        .high_cnt (high_cnt8)
`else
        .f_rise   (f_rise)
`endif
    );

    ep01_a #(.TRUTH_TABLE(8'b1000_0000)) u_and3 (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .c        (c),
        .f        (f_and),
        .f_q      (f_q_and),
`ifdef EP01_COUNT_EN
        .f_rise   (f_rise_and),
        .high_cnt (high_cnt8_and)
`else
        .f_rise   (f_rise_and)
`endif
    );

`ifdef EP01_COUNT_EN
    ep01_a #(.CNT_W(2)) u_cnt2 (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .c        (c),
        .f        (f_c2),
        .f_q      (f_q_c2),
        .f_rise   (f_rise_c2),
        .high_cnt (high_cnt2)
    );
`endif

    task automatic applyStimulus(input logic rst, input logic [2:0] abc);
        reset = rst;
        {a, b, c} = abc;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_default;
    logic [7:0] exp_and3;

    initial begin
        exp_default = 8'b1110_0010;
        exp_and3    = 8'b1000_0000;
        applyStimulus(1'b1, 3'b000);

        // Combinational sweep: no clock edge needed, 10 time units per vector.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 3'(i));
            #1;
            checkOutput($sformatf("sweep_f_%0d", i), {31'd0, f}, {31'd0, exp_default[i]});
            checkOutput($sformatf("sweep_and3_%0d", i), {31'd0, f_and}, {31'd0, exp_and3[i]});
            #9;
        end

        // Reset held for two edges with abc=111.
        applyStimulus(1'b1, 3'b111);
        tick();
        tick();
        checkOutput("rst_f", {31'd0, f}, 32'd1);
        checkOutput("rst_f_q", {31'd0, f_q}, 32'd0);
        checkOutput("rst_f_rise", {31'd0, f_rise}, 32'd0);
`ifdef EP01_COUNT_EN
        checkOutput("rst_cnt2", {30'd0, high_cnt2}, 32'd0);
`endif

        // Release: f_q loads 1, one rise pulse, then steady.
        applyStimulus(1'b0, 3'b111);
        tick();
        checkOutput("rel_f_q", {31'd0, f_q}, 32'd1);
        checkOutput("rel_f_rise", {31'd0, f_rise}, 32'd1);
        checkOutput("rel_and3_f_q", {31'd0, f_q_and}, 32'd1);
`ifdef EP01_COUNT_EN
        checkOutput("cnt2_e1", {30'd0, high_cnt2}, 32'd0);
`endif
        tick();
        checkOutput("hold_f_q", {31'd0, f_q}, 32'd1);
        checkOutput("hold_f_rise", {31'd0, f_rise}, 32'd0);
`ifdef EP01_COUNT_EN
        checkOutput("cnt2_e2", {30'd0, high_cnt2}, 32'd1);
        tick();
        checkOutput("cnt2_e3", {30'd0, high_cnt2}, 32'd2);
        tick();
        checkOutput("cnt2_e4", {30'd0, high_cnt2}, 32'd3);
        tick();
        checkOutput("cnt2_e5", {30'd0, high_cnt2}, 32'd3);
        tick();
        checkOutput("cnt2_e6", {30'd0, high_cnt2}, 32'd3);
        checkOutput("cnt8_e6", {24'd0, high_cnt8}, 32'd5);
        applyStimulus(1'b1, 3'b111);
        tick();
        checkOutput("cnt2_rst", {30'd0, high_cnt2}, 32'd0);
        checkOutput("cnt8_rst", {24'd0, high_cnt8}, 32'd0);
`endif
        checkOutput("steady_f_rise", {31'd0, f_rise}, 32'd0);

        // Toggle 000 -> 101 -> 000 -> 101 -> 000, one change per edge.
        applyStimulus(1'b0, 3'b000);
        tick();
        checkOutput("tog0_f_q", {31'd0, f_q}, 32'd0);
        applyStimulus(1'b0, 3'b101);
        tick();
        checkOutput("tog1_f_q", {31'd0, f_q}, 32'd1);
        checkOutput("tog1_f_rise", {31'd0, f_rise}, 32'd1);
        checkOutput("tog1_and3_f_q", {31'd0, f_q_and}, 32'd0);
        applyStimulus(1'b0, 3'b000);
        tick();
        checkOutput("tog2_f_q", {31'd0, f_q}, 32'd0);
        checkOutput("tog2_f_rise", {31'd0, f_rise}, 32'd0);
        applyStimulus(1'b0, 3'b101);
        tick();
        checkOutput("tog3_f_q", {31'd0, f_q}, 32'd1);
        checkOutput("tog3_f_rise", {31'd0, f_rise}, 32'd1);
        applyStimulus(1'b0, 3'b000);
        tick();
        checkOutput("tog4_f_q", {31'd0, f_q}, 32'd0);
        checkOutput("tog4_f_rise", {31'd0, f_rise}, 32'd0);

        // Glitch to 101 between edges, back to 000 well before the next edge.
        applyStimulus(1'b0, 3'b101);
        #2;
        checkOutput("glitch_f", {31'd0, f}, 32'd1);
        applyStimulus(1'b0, 3'b000);
        tick();
        checkOutput("glitch_f_q", {31'd0, f_q}, 32'd0);
        checkOutput("glitch_f_rise", {31'd0, f_rise}, 32'd0);

        // Steady 1 from abc=110 gives one pulse only.
        applyStimulus(1'b0, 3'b110);
        tick();
        checkOutput("st_f_rise1", {31'd0, f_rise}, 32'd1);
        tick();
        checkOutput("st_f_rise2", {31'd0, f_rise}, 32'd0);
        checkOutput("st_f_q2", {31'd0, f_q}, 32'd1);

        // Reset mid-run: registers clear, f stays live.
        applyStimulus(1'b1, 3'b110);
        tick();
        checkOutput("mid_rst_f", {31'd0, f}, 32'd1);
        checkOutput("mid_rst_f_q", {31'd0, f_q}, 32'd0);
        checkOutput("mid_rst_f_rise", {31'd0, f_rise}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
